// File: rtl/qsn_pkg.sv
// qsn_pkg: shared constants and lane-index helper for the Z=15 shift network
package qsn_pkg;
  localparam int QSN_Z = 15;
  localparam int QSN_MSG_W = 4;
  localparam int QSN_SHIFT_W = 4;
  localparam int QSN_DATA_W = QSN_Z * QSN_MSG_W;
  localparam logic [QSN_SHIFT_W-1:0] QSN_SHIFT_ILLEGAL = 4'd15;
  function automatic int qsn_mod(input int x);
    return ((x % QSN_Z) + QSN_Z) % QSN_Z;
  endfunction
endpackage

// File: rtl/qsn_rot_stage.sv
// qsn_rot_stage: one registered elastic stage applying a right cyclic lane rotation
module qsn_rot_stage import qsn_pkg::*; #(
  parameter int ROT_W = 2,
  parameter int SIDE_W = 1
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  up_valid,
  input  logic                  drain,
  input  logic [ROT_W-1:0]      rot,
  input  logic [QSN_DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0]     in_side,
  output logic                  load,
  output logic                  valid,
  output logic [QSN_DATA_W-1:0] data,
  output logic [SIDE_W-1:0]     side
);
  logic [QSN_DATA_W-1:0] rot_data;
  assign load = up_valid && (!valid || drain);
  // output lane j takes input lane (j - rot) mod Z
  always_comb begin
    rot_data = '0;
    for (int j = 0; j < QSN_Z; j++)
      rot_data[j*QSN_MSG_W +: QSN_MSG_W] = in_data[qsn_mod(j - int'(rot))*QSN_MSG_W +: QSN_MSG_W];
  end
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      data <= '0;
      side <= '0;
    end else begin
      valid <= load || (valid && !drain);
      if (load) begin
        data <= rot_data;
        side <= in_side;
      end
    end
  end
endmodule

// File: rtl/qsn_inv_rotate_len15.sv
// qsn_inv_rotate_len15: inverse Z=15 quasi-cyclic rotation, coarse (4*s[3:2]) then fine (s[1:0])
module qsn_inv_rotate_len15 import qsn_pkg::*; (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [QSN_DATA_W-1:0]  in_msg,
  input  logic [QSN_SHIFT_W-1:0] in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [QSN_DATA_W-1:0]  out_msg,
  output logic                   out_err
);
  logic illegal;
  logic [3:0] rot_a;
  logic [2:0] side_in;
  logic a_valid;
  logic b_load;
  logic unused_a_load;
  logic [QSN_DATA_W-1:0] a_data;
  logic [2:0] a_side;
  // an illegal shift passes the beat through unrotated and flags it
  always_comb begin
    illegal = in_shift == QSN_SHIFT_ILLEGAL;
    rot_a = illegal ? 4'd0 : {in_shift[3:2], 2'b00};
    side_in = {illegal ? 2'b00 : in_shift[1:0], illegal};
  end
  assign in_ready = !a_valid || b_load;
  qsn_rot_stage #(.ROT_W(4), .SIDE_W(3)) stage_a (
    .sys_clk(sys_clk),
    .rstn(rstn),
    .up_valid(in_valid),
    .drain(b_load),
    .rot(rot_a),
    .in_data(in_msg),
    .in_side(side_in),
    .load(unused_a_load),
    .valid(a_valid),
    .data(a_data),
    .side(a_side)
  );
  qsn_rot_stage #(.ROT_W(2), .SIDE_W(1)) stage_b (
    .sys_clk(sys_clk),
    .rstn(rstn),
    .up_valid(a_valid),
    .drain(out_ready),
    .rot(a_side[2:1]),
    .in_data(a_data),
    .in_side(a_side[0]),
    .load(b_load),
    .valid(out_valid),
    .data(out_msg),
    .side(out_err)
  );
endmodule

// File: tb/tb_qsn_inv_rotate_len15.sv
// tb_qsn_inv_rotate_len15: directed self-checking bench for the inverse Z=15 rotator
module tb_qsn_inv_rotate_len15;
  import qsn_pkg::*;
  localparam logic [QSN_DATA_W-1:0] RAMP = 60'hEDCBA9876543210;
  logic sys_clk = 0;
  logic rstn = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [QSN_DATA_W-1:0] in_msg = '0;
  logic [QSN_SHIFT_W-1:0] in_shift = '0;
  logic out_valid;
  logic out_ready = 1;
  logic [QSN_DATA_W-1:0] out_msg;
  logic out_err;
  int tests = 0;
  int fails = 0;
  logic [QSN_DATA_W-1:0] orig [15];
  logic [QSN_DATA_W-1:0] held;
  logic [63:0] r;
  int sent, recv, first, stalls;

  qsn_inv_rotate_len15 dut (
    .sys_clk(sys_clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_msg(in_msg),
    .in_shift(in_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_msg(out_msg),
    .out_err(out_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // forward network: lane j receives lane (j+s) mod Z
  function automatic logic [QSN_DATA_W-1:0] fwd(input logic [QSN_DATA_W-1:0] v, input int s);
    logic [QSN_DATA_W-1:0] o;
    for (int j = 0; j < QSN_Z; j++)
      o[j*QSN_MSG_W +: QSN_MSG_W] = v[((j + s) % QSN_Z)*QSN_MSG_W +: QSN_MSG_W];
    return o;
  endfunction

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [3:0] s, input logic [QSN_DATA_W-1:0] exp, input logic e);
    in_valid = 1;
    in_msg = RAMP;
    in_shift = s;
    tick;
    in_valid = 0;
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    tick;
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_msg"}, 64'(out_msg), 64'(exp));
    check({tag, "_err"}, 64'(out_err), 64'(e));
    tick;
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    tick;
    tick;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_msg", 64'(out_msg), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rstn = 1;
    tick;
    single("id", 4'd0, RAMP, 1'b0);
    single("s1", 4'd1, 60'hDCBA9876543210E, 1'b0);
    single("s14", 4'd14, 60'h0EDCBA987654321, 1'b0);
    single("s7", 4'd7, 60'h76543210EDCBA98, 1'b0);
    single("s15", 4'd15, RAMP, 1'b1);
    // round trip over every legal shift, back to back
    for (int i = 0; i < 15; i++) begin
      r = {$urandom(), $urandom()};
      orig[i] = r[QSN_DATA_W-1:0];
    end
    for (int c = 0; c < 19; c++) begin
      if (c >= 2 && c < 17) begin
        check("rt_vld", 64'(out_valid), 64'd1);
        check($sformatf("rt_msg%0d", c - 2), 64'(out_msg), 64'(orig[c-2]));
        check("rt_err", 64'(out_err), 64'd0);
      end else check("rt_idle", 64'(out_valid), 64'd0);
      in_valid = c < 15;
      if (c < 15) begin
        in_msg = fwd(orig[c], c);
        in_shift = 4'(c);
      end
      #1;
      check("rt_rdy", 64'(in_ready), 64'd1);
      tick;
    end
    // illegal shift between legal neighbours
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        check("ill_vld", 64'(out_valid), 64'd1);
        check("ill_msg", 64'(out_msg), 64'(RAMP));
        check($sformatf("ill_err%0d", c - 2), 64'(out_err), (c == 3) ? 64'd1 : 64'd0);
      end else check("ill_idle", 64'(out_valid), 64'd0);
      in_valid = c < 3;
      in_shift = (c == 0) ? 4'd3 : (c == 1) ? 4'd15 : 4'd5;
      in_msg = (c == 0) ? fwd(RAMP, 3) : (c == 1) ? RAMP : fwd(RAMP, 5);
      tick;
    end
    in_valid = 0;
    // backpressure: 4 beats, out_ready low for 3 cycles from first out_valid
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      orig[i] = r[QSN_DATA_W-1:0];
    end
    sent = 0;
    recv = 0;
    first = -1;
    stalls = 0;
    for (int c = 0; c < 30 && recv < 4; c++) begin
      if (out_valid && first < 0) first = c;
      out_ready = !(first >= 0 && c < first + 3);
      in_valid = sent < 4;
      in_msg = fwd(orig[sent % 4], sent + 2);
      in_shift = 4'(sent + 2);
      #1;
      if (out_valid && !out_ready) begin
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        if (stalls > 0) check("bp_hold", 64'(out_msg), 64'(held));
        held = out_msg;
        stalls++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_msg%0d", recv), 64'(out_msg), 64'(orig[recv]));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 0;
    out_ready = 1;
    check("bp_recv", 64'(recv), 64'd4);
    check("bp_stalls", 64'(stalls), 64'd3);
    tick;
    check("bp_nodup", 64'(out_valid), 64'd0);
    // reset with two beats buffered
    out_ready = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1;
      in_msg = RAMP;
      in_shift = (c == 0) ? 4'd15 : 4'd2;
      tick;
    end
    in_valid = 0;
    #1;
    check("mr_pre_vld", 64'(out_valid), 64'd1);
    check("mr_pre_err", 64'(out_err), 64'd1);
    check("mr_pre_rdy", 64'(in_ready), 64'd0);
    rstn = 0;
    tick;
    rstn = 1;
    #1;
    check("mr_vld", 64'(out_valid), 64'd0);
    check("mr_msg", 64'(out_msg), 64'd0);
    check("mr_err", 64'(out_err), 64'd0);
    check("mr_rdy", 64'(in_ready), 64'd1);
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("mr_stale", 64'(out_valid), 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
